// File: rtl/pico_tb_pkg.sv
// Shared types and constants for the pico_test_mem bench memory.
// Includes the stall LFSR constants used when PICO_MEM_STALL_LFSR_EN is defined.
package pico_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [31:0] PASS_VALUE_DEF = 32'd123456789;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> bit indices 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pico_stall_lfsr.sv
// 16-bit Fibonacci LFSR supplying random stall cycles; advances once per step.
// Only instantiated when PICO_MEM_STALL_LFSR_EN is defined.
module pico_stall_lfsr
    import pico_tb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/pico_test_mem.sv
// Bench memory for the PicoRV32 native bus: RAM, pass/fail register and console port.
// Define PICO_MEM_STALL_LFSR_EN to add 0..3 random wait cycles per request.
module pico_test_mem
    import pico_tb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] PASS_ADDR   = 32'h2000_0000,
    parameter logic [31:0] CONS_ADDR   = 32'h1000_0000,
    parameter logic [31:0] PASS_VALUE  = PASS_VALUE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        tests_passed,
    output logic        tests_failed,
    output logic        bus_err,
    output logic        cons_valid,
    output logic [7:0]  cons_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] sram [DEPTH_WORDS];

    state_t      r_state, w_state_next;
    logic [4:0]  r_cnt, w_cnt_next, w_load;
    logic [1:0]  w_stall;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_passed, r_failed, r_bus_err, r_cons_valid;
    logic [7:0]  r_cons_data;

    logic        w_capture, w_enter_resp, w_is_write;
    logic        w_hit_pass, w_hit_cons, w_hit_ram;
    logic [29:0] w_req_word;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_wstrb;
    logic [AW-1:0] w_idx;
    logic        w_unused_addr;

`ifdef PICO_MEM_STALL_LFSR_EN
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    pico_stall_lfsr u_stall_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (w_capture),
        .value (w_lfsr)
    );

    assign w_stall       = w_lfsr[1:0];
    assign w_unused_lfsr = ^w_lfsr[15:2];
`else
    assign w_stall = 2'd0;
`endif

    assign w_unused_addr = ^mem_addr[1:0];
    assign w_capture     = (r_state == ST_IDLE) && mem_valid;
    assign w_load        = 5'(LATENCY) + {3'b000, w_stall};

    // With zero wait the access happens on the capture edge, so decode the live bus in IDLE.
    assign w_req_word  = (r_state == ST_IDLE) ? mem_addr[31:2] : r_word;
    assign w_req_wdata = (r_state == ST_IDLE) ? mem_wdata      : r_wdata;
    assign w_req_wstrb = (r_state == ST_IDLE) ? mem_wstrb      : r_wstrb;
    assign w_is_write  = (w_req_wstrb != 4'b0000);
    assign w_idx       = w_req_word[AW-1:0];

    assign w_hit_pass = (w_req_word == PASS_ADDR[31:2]);
    assign w_hit_cons = !w_hit_pass && (w_req_word == CONS_ADDR[31:2]);
    assign w_hit_ram  = !w_hit_pass && !w_hit_cons && ({2'b00, w_req_word} < DEPTH_WORDS);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    w_cnt_next   = w_load;
                    w_state_next = (w_load == 5'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_next == ST_RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_word  <= 30'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_word  <= mem_addr[31:2];
                r_wdata <= mem_wdata;
                r_wstrb <= mem_wstrb;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rdata      <= 32'd0;
            r_passed     <= 1'b0;
            r_failed     <= 1'b0;
            r_bus_err    <= 1'b0;
            r_cons_valid <= 1'b0;
            r_cons_data  <= 8'd0;
        end else begin
            r_cons_valid <= 1'b0;
            if (w_enter_resp) begin
                r_rdata <= 32'd0;
                if (w_hit_pass) begin
                    if (!w_is_write) begin
                        r_rdata <= {30'd0, r_failed, r_passed};
                    end else if (w_req_wdata == PASS_VALUE) begin
                        r_passed <= 1'b1;
                    end else begin
                        r_failed <= 1'b1;
                    end
                end else if (w_hit_cons) begin
                    if (w_is_write) begin
                        r_cons_valid <= 1'b1;
                        r_cons_data  <= w_req_wdata[7:0];
                    end
                end else if (w_hit_ram) begin
                    if (!w_is_write) begin
                        r_rdata <= sram[w_idx];
                    end
                end else begin
                    r_bus_err <= 1'b1;
                end
            end
        end
    end

    // No reset on the array so preloaded contents survive and it maps onto RAM.
    always_ff @(posedge clock) begin
        if (reset && w_enter_resp && w_is_write && w_hit_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req_wstrb[b]) begin
                    sram[w_idx][8*b +: 8] <= w_req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready    = (r_state == ST_RESP);
    assign mem_rdata    = r_rdata;
    assign tests_passed = r_passed;
    assign tests_failed = r_failed;
    assign bus_err      = r_bus_err;
    assign cons_valid   = r_cons_valid;
    assign cons_data    = r_cons_data;

endmodule

// File: tb/tb_pico_test_mem.sv
// Directed bench for pico_test_mem: one LATENCY=0 and one LATENCY=3 instance.
// Adds a stall-distribution step when PICO_MEM_STALL_LFSR_EN is defined.
module tb_pico_test_mem;

    localparam int unsigned DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        v0 = 1'b0, v3 = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;

    logic        rdy0, tp0, tf0, be0, cv0;
    logic        rdy3, tp3, tf3, be3, cv3;
    logic [31:0] rdata0, rdata3;
    logic [7:0]  cd0, cd3;

    int          checks = 0;
    int          failures = 0;
    int          last_lat;
    logic [31:0] last_rdata;
    logic        last_cv, last_rdy_after;
    logic [7:0]  last_cd;

    always #5 clock = ~clock;

    pico_test_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset), .mem_valid(v0), .mem_ready(rdy0),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata0),
        .tests_passed(tp0), .tests_failed(tf0), .bus_err(be0),
        .cons_valid(cv0), .cons_data(cd0)
    );

    pico_test_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .mem_valid(v3), .mem_ready(rdy3),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata3),
        .tests_passed(tp3), .tests_failed(tf3), .bus_err(be3),
        .cons_valid(cv3), .cons_data(cd3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fixed build: exact latency. Stall build: base..base+3.
    task automatic check_lat(input string tag, input int lat, input int base);
`ifdef PICO_MEM_STALL_LFSR_EN
        check(tag, 32'(lat >= base && lat <= base + 3), 32'd1);
`else
        check(tag, 32'(lat), 32'(base));
`endif
    endtask

    // Latency counts edges from capture to the edge that samples mem_ready high.
    task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold);
        addr  = a;
        wdata = d;
        wstrb = s;
        if (sel == 0) v0 = 1'b1; else v3 = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) begin
            v0 = 1'b0;
            v3 = 1'b0;
        end
        last_lat = 0;
        do begin
            @(negedge clock);
            last_lat++;
        end while (!((sel == 0) ? rdy0 : rdy3) && last_lat < 40);
        if (!((sel == 0) ? rdy0 : rdy3)) last_lat = -1;
        last_rdata = (sel == 0) ? rdata0 : rdata3;
        last_cv    = (sel == 0) ? cv0 : cv3;
        last_cd    = (sel == 0) ? cd0 : cd3;
        @(posedge clock);
        #1;
        v0 = 1'b0;
        v3 = 1'b0;
        last_rdy_after = (sel == 0) ? rdy0 : rdy3;
    endtask

    initial begin
        int seen;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready",  32'(rdy0), 32'd0);
        check("rst_rdata",  rdata0, 32'd0);
        check("rst_flags",  {28'd0, tp0, tf0, be0, cv0}, 32'd0);
        check("rst_cdata",  32'(cd0), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd0);
        reset = 1'b1;

        // LATENCY=0 write then read
        xfer(0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
        check_lat("l0_wr_lat", last_lat, 1);
        check("l0_wr_rdata", last_rdata, 32'd0);
        xfer(0, 32'h100, 32'd0, 4'h0, 1'b1);
        check_lat("l0_rd_lat", last_lat, 1);
        check("l0_rd_data", last_rdata, 32'hDEADBEEF);

        // Partial byte-lane write
        xfer(0, 32'h200, 32'h11223344, 4'hF, 1'b1);
        xfer(0, 32'h200, 32'hAABBCCDD, 4'b0101, 1'b1);
        xfer(0, 32'h200, 32'd0, 4'h0, 1'b1);
        check("wstrb_merge", last_rdata, 32'h11BB33DD);

        // LATENCY=3 timing, single-cycle ready, back-to-back acceptance
        xfer(3, 32'h0, 32'h0BADF00D, 4'hF, 1'b1);
        check_lat("l3_wr_lat", last_lat, 4);
        check("l3_ready_1cyc", 32'(last_rdy_after), 32'd0);
        xfer(3, 32'h0, 32'd0, 4'h0, 1'b1);
        check_lat("l3_b2b_lat", last_lat, 4);
        check("l3_rd_data", last_rdata, 32'h0BADF00D);

        // Valid dropped right after capture still completes
        xfer(3, 32'h10, 32'h5555AAAA, 4'hF, 1'b0);
        check_lat("l3_drop_lat", last_lat, 4);
        xfer(3, 32'h10, 32'd0, 4'h0, 1'b0);
        check("l3_drop_data", last_rdata, 32'h5555AAAA);

        // Pass/fail register
        xfer(0, 32'h2000_0000, 32'd123456789, 4'hF, 1'b1);
        check("pass_set", {30'd0, tp0, tf0}, 32'd2);
        xfer(0, 32'h2000_0000, 32'd5, 4'hF, 1'b1);
        check("fail_set", {30'd0, tp0, tf0}, 32'd3);
        xfer(0, 32'h2000_0000, 32'd0, 4'h0, 1'b1);
        check("pass_read", last_rdata, 32'h3);

        // Console port
        xfer(0, 32'h1000_0000, 32'h00000041, 4'h1, 1'b1);
        check("cons_pulse", {23'd0, last_cv, last_cd}, {23'd0, 1'b1, 8'h41});
        check("cons_clear", 32'(cv0), 32'd0);
        xfer(0, 32'h1000_0000, 32'd0, 4'h0, 1'b1);
        check("cons_read", last_rdata, 32'd0);

        // Top word mapped, next word unmapped, no aliasing
        xfer(0, 32'h0, 32'h5A5A5A5A, 4'hF, 1'b1);
        xfer(0, 4 * DEPTH - 4, 32'h600DCAFE, 4'hF, 1'b1);
        xfer(0, 4 * DEPTH - 4, 32'd0, 4'h0, 1'b1);
        check("top_word", last_rdata, 32'h600DCAFE);
        check("top_no_err", 32'(be0), 32'd0);
        xfer(0, 4 * DEPTH, 32'd0, 4'h0, 1'b1);
        check("unmap_rdata", last_rdata, 32'd0);
        check("unmap_err", 32'(be0), 32'd1);
        xfer(0, 4 * DEPTH, 32'hFFFFFFFF, 4'hF, 1'b1);
        xfer(0, 32'h0, 32'd0, 4'h0, 1'b1);
        check("no_alias", last_rdata, 32'h5A5A5A5A);

        // Reset during WAIT discards the write
        xfer(3, 32'h300, 32'h12345678, 4'hF, 1'b1);
        addr  = 32'h300;
        wdata = 32'hCAFEF00D;
        wstrb = 4'hF;
        v3    = 1'b1;
        @(posedge clock);
        #1;
        v3    = 1'b0;
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(negedge clock);
            if (rdy3) seen++;
        end
        check("rst_mid_noready", 32'(seen), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        xfer(3, 32'h300, 32'd0, 4'h0, 1'b1);
        check("rst_mid_data", last_rdata, 32'h12345678);
        check("rst_flags3", {29'd0, tp3, tf3, be3}, 32'd0);

`ifdef PICO_MEM_STALL_LFSR_EN
        begin
            int hist [4];
            int bad;
            bad = 0;
            for (int k = 0; k < 4; k++) hist[k] = 0;
            for (int n = 0; n < 1000; n++) begin
                xfer(3, 32'h0, 32'd0, 4'h0, 1'b1);
                if (last_lat < 4 || last_lat > 7) bad++;
                else hist[last_lat - 4]++;
            end
            check("lfsr_range", 32'(bad), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("lfsr_bin%0d", k), 32'(hist[k] != 0), 32'd1);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
